multicycle_ctrl: RTL and testbench

// - Multi-cycle control FSM for the RV32I Fibonacci core; the producing end of the ALU control interface.
// - Decodes the IR and drives alucontrol plus the datapath selects and enables each cycle.
// - Drives the unified instruction/data memory request handshake.
// - Consumes the ALU zero flag to resolve branches.

---
 rtl/rv32_pkg.sv | 50 +++++
 rtl/alu_dec.sv | 42 ++++
 rtl/multicycle_ctrl.sv | 153 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: ALU ops, opcodes,
// FSM states, decode classes and datapath select values.
package rv32_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_EQ   = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10
  } alu_op_t;

  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  // Which funct3 table the ALU decoder applies; CLS_ADD forces a plain add.
  typedef enum logic [1:0] {
    CLS_ADD, CLS_R, CLS_I, CLS_BR
  } dec_class_t;

  localparam logic [1:0] SRC_A_RS1   = 2'd0;
  localparam logic [1:0] SRC_A_PC    = 2'd1;
  localparam logic [1:0] SRC_A_OLDPC = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

endpackage

// File: rtl/alu_dec.sv
// Combinational ALU opcode decoder: {class, funct3, f7b5} -> alu_op_t, plus a
// flag for funct3 values that have no meaning in the selected class.
module alu_dec
  import rv32_pkg::*;
(
  input  dec_class_t  cls,
  input  logic [2:0]  funct3,
  input  logic        f7b5,
  output alu_op_t     alu_op_c,
  output logic        bad_funct_c
);

  always_comb begin
    alu_op_c    = ALU_ADD;
    bad_funct_c = 1'b0;
    case (cls)
      CLS_R, CLS_I: begin
        case (funct3)
          // OP-IMM has no subtract; instr[30] is immediate data for ADDI
          3'b000: alu_op_c = (cls == CLS_R && f7b5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_op_c = ALU_SLL;
          3'b010: alu_op_c = ALU_SLT;
          3'b011: alu_op_c = ALU_SLTU;
          3'b100: alu_op_c = ALU_XOR;
          3'b101: alu_op_c = f7b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_op_c = ALU_OR;
          3'b111: alu_op_c = ALU_AND;
        endcase
      end
      CLS_BR: begin
        case (funct3)
          3'b000, 3'b001: alu_op_c = ALU_SUB;
          3'b100, 3'b101: alu_op_c = ALU_SLT;
          3'b110, 3'b111: alu_op_c = ALU_SLTU;
          default:        bad_funct_c = 1'b1;
        endcase
      end
      default: alu_op_c = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch/decode/execute,
// drives datapath selects and enables, and the unified memory handshake.
module multicycle_ctrl
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] instr,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic            addr_sel,
  output logic            ir_we,
  output logic            pc_we,
  output logic            pc_src,
  output logic [1:0]      alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [3:0]      alucontrol,
  output logic            reg_we,
  output logic [1:0]      wb_sel,
  output logic            illegal
);

  state_t           state_q, state_d;
  dec_class_t       cls;
  alu_op_t          alu_op_c;
  logic             bad_funct_c;
  logic             taken;
  logic [OPC_W-1:0] opcode;
  logic [2:0]       funct3;
  logic             f7b5;
  logic             unused_instr_bits;

  assign opcode = instr[OPC_W-1:0];
  assign funct3 = instr[14:12];
  assign f7b5   = instr[30];
  assign unused_instr_bits = ^{instr[XLEN-1:31], instr[29:15], instr[11:7]};

  // Branches compare with SUB/SLT/SLTU; funct3[0]^funct3[2] flips the sense of zero
  assign taken = zero ^ (funct3[0] ^ funct3[2]);

  alu_dec u_alu_dec (
    .cls         (cls),
    .funct3      (funct3),
    .f7b5        (f7b5),
    .alu_op_c    (alu_op_c),
    .bad_funct_c (bad_funct_c)
  );

  assign alucontrol = 4'(alu_op_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cls       = CLS_ADD;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    alu_src_a = SRC_A_RS1;
    alu_src_b = SRC_B_RS2;
    reg_we    = 1'b0;
    wb_sel    = WB_ALUOUT;
    illegal   = 1'b0;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_IMM:             state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JAL;
          default:            state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        cls     = CLS_R;
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        cls       = CLS_I;
        alu_src_b = SRC_B_IMM;
        state_d   = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_b = SRC_B_IMM;
        state_d   = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_we  = 1'b1;
        wb_sel  = WB_MDR;
        state_d = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        cls = CLS_BR;
        if (bad_funct_c) begin
          state_d = S_TRAP;
        end else begin
          pc_we   = taken;
          pc_src  = taken;
          state_d = S_FETCH;
        end
      end
      S_JAL: begin
        reg_we  = 1'b1;
        wb_sel  = WB_PC;
        pc_we   = 1'b1;
        pc_src  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: illegal = 1'b1;
      default: state_d = S_RST;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected output vectors are
// queued with their stimulus and compared as the FSM steps through them.
module tb_multicycle_ctrl;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we, illegal;
  logic [1:0]  alu_src_a, alu_src_b, wb_sel;
  logic [3:0]  alucontrol;

  multicycle_ctrl #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .addr_sel   (addr_sel),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alucontrol (alucontrol),
    .reg_we     (reg_we),
    .wb_sel     (wb_sel),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req, we, asel, irwe, pcwe, pcsrc;
    logic [1:0] sa, sb;
    logic [3:0] alu;
    logic       rwe;
    logic [1:0] wb;
    logic       ill;
  } out_t;

  typedef struct {
    string       tag;
    logic [31:0] ins;
    logic        z;
    logic        rdy;
    out_t        exp;
  } step_t;

  out_t  obs;
  step_t sb_q[$];
  int    n_chk = 0;
  int    n_pass = 0;

  assign obs = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src_a,
                alu_src_b, alucontrol, reg_we, wb_sel, illegal};

  function automatic out_t o_fetch(input logic rdy);
    out_t o = '0;
    o.req = 1'b1; o.sa = 2'd1; o.sb = 2'd2; o.irwe = rdy; o.pcwe = rdy;
    return o;
  endfunction

  function automatic out_t o_decode();
    out_t o = '0;
    o.sa = 2'd2; o.sb = 2'd1;
    return o;
  endfunction

  function automatic out_t o_exec(input logic [1:0] sb, input logic [3:0] alu);
    out_t o = '0;
    o.sb = sb; o.alu = alu;
    return o;
  endfunction

  function automatic out_t o_wb(input logic [1:0] wb);
    out_t o = '0;
    o.rwe = 1'b1; o.wb = wb;
    return o;
  endfunction

  function automatic out_t o_mem(input logic we);
    out_t o = '0;
    o.req = 1'b1; o.we = we; o.asel = 1'b1;
    return o;
  endfunction

  function automatic out_t o_branch(input logic [3:0] alu, input logic tk);
    out_t o = '0;
    o.alu = alu; o.pcwe = tk; o.pcsrc = tk;
    return o;
  endfunction

  function automatic out_t o_jal();
    out_t o = '0;
    o.rwe = 1'b1; o.wb = 2'd2; o.pcwe = 1'b1; o.pcsrc = 1'b1;
    return o;
  endfunction

  function automatic out_t o_trap();
    out_t o = '0;
    o.ill = 1'b1;
    return o;
  endfunction

  task automatic push(input string tag, input logic [31:0] ins, input logic z,
                      input logic rdy, input out_t exp);
    step_t s;
    s.tag = tag; s.ins = ins; s.z = z; s.rdy = rdy; s.exp = exp;
    sb_q.push_back(s);
  endtask

  task automatic check(input string tag, input out_t exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  // Entered at a falling edge: drive, settle, compare, advance one cycle.
  task automatic drain();
    step_t s;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      instr = s.ins; zero = s.z; mem_ready = s.rdy;
      #2;
      check(s.tag, s.exp);
      @(negedge clk);
    end
  endtask

  task automatic seq_alu(input string tag, input logic [31:0] ins,
                         input logic [1:0] sb, input logic [3:0] alu);
    push({tag, "_fetch"}, ins, 1'b0, 1'b1, o_fetch(1'b1));
    push({tag, "_decode"}, ins, 1'b0, 1'b1, o_decode());
    push({tag, "_exec"}, ins, 1'b0, 1'b1, o_exec(sb, alu));
    push({tag, "_wb"}, ins, 1'b0, 1'b1, o_wb(2'd0));
    drain();
  endtask

  task automatic seq_branch(input string tag, input logic [31:0] ins, input logic z,
                            input logic [3:0] alu, input logic tk);
    push({tag, "_fetch"}, ins, 1'b0, 1'b1, o_fetch(1'b1));
    push({tag, "_decode"}, ins, 1'b0, 1'b1, o_decode());
    push({tag, "_branch"}, ins, z, 1'b1, o_branch(alu, tk));
    drain();
  endtask

  initial begin
    mem_ready = 1'b1;
    @(negedge clk);
    #2 check("reset_hold", '0);
    @(negedge clk);
    rst_n = 1'b1;
    push("rst_cycle", 32'h0, 1'b0, 1'b1, '0);
    drain();

    seq_alu("add",  32'h002081B3, 2'd0, 4'd0);
    seq_alu("sub",  32'h402081B3, 2'd0, 4'd1);
    seq_alu("srai", 32'h4020D193, 2'd1, 4'd10);
    seq_alu("addi_b30", 32'h40008193, 2'd1, 4'd0);
    seq_alu("and",  32'h0020F1B3, 2'd0, 4'd2);

    seq_branch("bne_z0",  32'h00209463, 1'b0, 4'd1, 1'b1);
    seq_branch("bne_z1",  32'h00209463, 1'b1, 4'd1, 1'b0);
    seq_branch("blt_z0",  32'h0020C463, 1'b0, 4'd6, 1'b1);
    seq_branch("bge_z1",  32'h0020D463, 1'b1, 4'd6, 1'b1);
    seq_branch("bltu_z1", 32'h0020E463, 1'b1, 4'd7, 1'b0);

    push("jal_fetch", 32'h008000EF, 1'b0, 1'b1, o_fetch(1'b1));
    push("jal_decode", 32'h008000EF, 1'b0, 1'b1, o_decode());
    push("jal_exec", 32'h008000EF, 1'b0, 1'b1, o_jal());
    drain();

    // Load with three wait states in MEM_RD: 8 cycles in total
    push("lw_fetch", 32'h0000A183, 1'b0, 1'b1, o_fetch(1'b1));
    push("lw_decode", 32'h0000A183, 1'b0, 1'b1, o_decode());
    push("lw_addr", 32'h0000A183, 1'b0, 1'b1, o_exec(2'd1, 4'd0));
    for (int i = 0; i < 3; i++)
      push("lw_rd_wait", 32'h0000A183, 1'b0, 1'b0, o_mem(1'b0));
    push("lw_rd_done", 32'h0000A183, 1'b0, 1'b1, o_mem(1'b0));
    push("lw_wb", 32'h0000A183, 1'b0, 1'b1, o_wb(2'd1));
    drain();

    push("sw_fetch_wait", 32'h0020A023, 1'b0, 1'b0, o_fetch(1'b0));
    push("sw_fetch", 32'h0020A023, 1'b0, 1'b1, o_fetch(1'b1));
    push("sw_decode", 32'h0020A023, 1'b0, 1'b1, o_decode());
    push("sw_addr", 32'h0020A023, 1'b0, 1'b1, o_exec(2'd1, 4'd0));
    push("sw_wr_wait", 32'h0020A023, 1'b0, 1'b0, o_mem(1'b1));
    push("sw_wr_done", 32'h0020A023, 1'b0, 1'b1, o_mem(1'b1));
    push("after_sw_fetch", 32'h0000A183, 1'b0, 1'b1, o_fetch(1'b1));
    push("lw2_decode", 32'h0000A183, 1'b0, 1'b1, o_decode());
    push("lw2_addr", 32'h0000A183, 1'b0, 1'b1, o_exec(2'd1, 4'd0));
    push("lw2_rd_wait", 32'h0000A183, 1'b0, 1'b0, o_mem(1'b0));
    drain();

    // Asynchronous reset while parked in MEM_RD
    rst_n = 1'b0;
    #2 check("rst_mid_memrd", '0);
    @(negedge clk);
    rst_n = 1'b1;
    push("rst2_cycle", 32'h0000A183, 1'b0, 1'b1, '0);
    push("rst2_fetch", 32'h0000A183, 1'b0, 1'b0, o_fetch(1'b0));
    push("rst2_fetch_go", 32'h0000007F, 1'b0, 1'b1, o_fetch(1'b1));
    push("bad_decode", 32'h0000007F, 1'b0, 1'b1, o_decode());
    for (int i = 0; i < 12; i++)
      push("trap_hold", 32'h0000007F, 1'b0, 1'b1, o_trap());
    drain();

    rst_n = 1'b0;
    #2 check("rst_clears_trap", '0);
    @(negedge clk);
    rst_n = 1'b1;
    push("rst3_cycle", 32'h002081B3, 1'b0, 1'b1, '0);
    push("rst3_fetch", 32'h002081B3, 1'b0, 1'b1, o_fetch(1'b1));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
